// File: rtl/input_bram_loader.sv
// Packs a 32-bit valid/ready word stream into 1024-bit lines and writes 64 lines into each of four input BRAM banks.
// Optional AUTO_START_EN: start_o pulses with load_done when the transfer finished without error.
module input_bram_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 1024,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_BANKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  en_wr,
  output logic [NUM_BANKS-1:0]  we_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [LINE_WIDTH-1:0] din_wr,
  output logic                  busy,
  output logic                  load_done,
  output logic                  err,
  output logic                  start_o
);

  localparam int WPL = LINE_WIDTH / WORD_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                  state;
  logic [4:0]              word_cnt;
  logic [ADDR_WIDTH-1:0]   line_cnt;
  logic [1:0]              bank_sel;
  logic [LINE_WIDTH-1:0]   line_buf;
  logic [LINE_WIDTH-1:0]   line_next;
  logic                    accept;
  logic                    last_word;
  logic                    last_line;
  logic                    start_q;

  assign accept    = s_valid & s_ready;
  assign last_line = (bank_sel == 2'(NUM_BANKS - 1)) && (line_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign last_word = last_line && (word_cnt == 5'(WPL - 1));
  // New words enter at the top and shift down, so word 0 ends up in the LSBs after a full line.
  assign line_next = {s_data, line_buf[LINE_WIDTH-1:WORD_WIDTH]};

`ifdef AUTO_START_EN
  assign start_o = start_q;
`else
  assign start_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      en_wr     <= 1'b0;
      we_wr     <= '0;
      addr_wr   <= '0;
      din_wr    <= '0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      err       <= 1'b0;
      start_q   <= 1'b0;
      word_cnt  <= '0;
      line_cnt  <= '0;
      bank_sel  <= '0;
      line_buf  <= '0;
    end else begin
      en_wr     <= 1'b0;
      we_wr     <= '0;
      load_done <= 1'b0;
      start_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= FILL;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            word_cnt <= '0;
            line_cnt <= '0;
            bank_sel <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            line_buf <= line_next;
            word_cnt <= word_cnt + 5'd1;
            // An early s_last aborts the transfer and drops the partial line.
            if (s_last && !last_word) begin
              err     <= 1'b1;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              if (last_word && !s_last) err <= 1'b1;
              if (word_cnt == 5'(WPL - 1)) begin
                s_ready <= 1'b0;
                en_wr   <= 1'b1;
                we_wr   <= NUM_BANKS'(1) << bank_sel;
                addr_wr <= line_cnt;
                din_wr  <= line_next;
                state   <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          line_cnt <= line_cnt + ADDR_WIDTH'(1);
          if (line_cnt == ADDR_WIDTH'(DEPTH - 1)) bank_sel <= bank_sel + 2'd1;
          if (last_line) begin
            state     <= DONE;
            busy      <= 1'b0;
            load_done <= 1'b1;
            start_q   <= ~err;
          end else begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_bram_loader.sv
// Scoreboard bench for input_bram_loader: expected BRAM lines are queued when a transfer is started and popped on each write.
module tb_input_bram_loader;

  localparam int LW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic          en_wr;
  logic [3:0]    we_wr;
  logic [5:0]    addr_wr;
  logic [LW-1:0] din_wr;
  logic          busy;
  logic          load_done;
  logic          err;
  logic          start_o;

  input_bram_loader dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .en_wr(en_wr), .we_wr(we_wr), .addr_wr(addr_wr), .din_wr(din_wr),
    .busy(busy), .load_done(load_done), .err(err), .start_o(start_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    we;
    logic [5:0]    addr;
    logic [LW-1:0] data;
  } wr_t;

  wr_t  expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   doneCount = 0;
  int   doneCyc = 0;
  int   loadCyc = 0;
  int   base = 0;
  logic expErr = 1'b0;
  logic expStart;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] lineOf(input int b, input int n);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[32*k +: 32] = 32'(b*2048 + n*32 + k);
    return r;
  endfunction

  task automatic pushLines(input int count);
    wr_t e;
    for (int i = 0; i < count; i++) begin
      e.we   = 4'(1 << (i / 64));
      e.addr = 6'(i % 64);
      e.data = lineOf(i / 64, i % 64);
      expQ.push_back(e);
    end
  endtask

  // Write monitor and load_done/start_o tracker, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t e;
`ifdef AUTO_START_EN
    expStart = ~expErr;
`else
    expStart = 1'b0;
`endif
    if (en_wr) begin
      checkOutput("ready_in_write", s_ready, '0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", en_wr, '0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_we_addr", {we_wr, addr_wr}, {e.we, e.addr});
        checkOutput("wr_line", din_wr, e.data);
      end
    end
    if (load_done) begin
      doneCount++;
      doneCyc = cyc;
      checkOutput("start_o", start_o, expStart);
    end else if (start_o) begin
      checkOutput("start_stray", start_o, '0);
    end
  end

  task automatic doLoad();
    @(negedge clk);
    load = 1'b1;
    loadCyc = cyc;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic applyStimulus(input int nWords, input int gapPct, input int lastAt, input int loadAt);
    int idx = 0;
    int guard = 0;
    while (idx < nWords && guard < nWords * 20 + 2000) begin
      s_valid = ($urandom_range(99) >= gapPct);
      s_data  = 32'(idx);
      s_last  = (idx == lastAt);
      load    = (idx == loadAt);
      if (s_valid && s_ready) idx++;
      guard++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    load    = 1'b0;
    if (idx < nWords) checkOutput("send_timeout", LW'(idx), LW'(nWords));
  endtask

  task automatic waitDone(input int startCount, input int maxCyc);
    int n = 0;
    while (doneCount == startCount && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("load_done_seen", LW'(doneCount - startCount), LW'(1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {s_ready, en_wr, we_wr, addr_wr, busy, load_done, err, start_o}, '0);
    checkOutput("reset_din", din_wr, '0);
    rst_n = 1'b1;

    // Full transfer, s_valid held high.
    expErr = 1'b0;
    pushLines(256);
    base = doneCount;
    doLoad();
    applyStimulus(8192, 0, 8191, -1);
    waitDone(base, 100);
    checkOutput("latency", LW'(doneCyc - loadCyc), LW'(33*256 + 1));
    checkOutput("err_full", err, '0);
    checkOutput("queue_empty_full", LW'(expQ.size()), '0);
    checkOutput("busy_after_done", busy, '0);

    // Same data with ~30% idle cycles on s_valid.
    pushLines(256);
    base = doneCount;
    doLoad();
    applyStimulus(8192, 30, 8191, -1);
    waitDone(base, 100);
    checkOutput("err_gaps", err, '0);
    checkOutput("queue_empty_gaps", LW'(expQ.size()), '0);

    // Early s_last on word 100: lines 0..2 written, line 3 dropped.
    pushLines(3);
    base = doneCount;
    doLoad();
    applyStimulus(101, 0, 100, -1);
    repeat (40) @(negedge clk);
    checkOutput("err_early", err, 1'b1);
    checkOutput("busy_early", busy, '0);
    checkOutput("ready_early", s_ready, '0);
    checkOutput("queue_empty_early", LW'(expQ.size()), '0);
    checkOutput("no_done_early", LW'(doneCount - base), '0);

    // New load clears err; then no s_last on word 8191.
    expErr = 1'b1;
    pushLines(256);
    base = doneCount;
    doLoad();
    checkOutput("err_cleared", err, '0);
    applyStimulus(8192, 0, -1, -1);
    waitDone(base, 100);
    checkOutput("err_missing_last", err, 1'b1);
    checkOutput("queue_empty_missing", LW'(expQ.size()), '0);

    // Reset after 1000 words: 31 complete lines written, then everything clears.
    expErr = 1'b0;
    pushLines(31);
    doLoad();
    applyStimulus(1000, 0, -1, -1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctrl", {s_ready, en_wr, we_wr, addr_wr, busy, load_done, err, start_o}, '0);
    checkOutput("rst_mid_din", din_wr, '0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("queue_empty_reset", LW'(expQ.size()), '0);

    // Full transfer from bank 0 line 0 with a stray load pulse at word 500.
    pushLines(256);
    base = doneCount;
    doLoad();
    applyStimulus(8192, 0, 8191, 500);
    waitDone(base, 100);
    checkOutput("latency_stray_load", LW'(doneCyc - loadCyc), LW'(33*256 + 1));
    checkOutput("err_stray_load", err, '0);
    checkOutput("queue_empty_stray", LW'(expQ.size()), '0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
